// File: rtl/exec_stage.sv
// Execute stage: decodes the entry in flight into an ALU op and operands,
// drives the external combinational ALU, resolves branches/jumps and registers
// the result behind a valid/ready handshake with stall and flush.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop every in-flight entry at the next edge
//   in_*                upstream entry and handshake (in_ready is combinational)
//   alu_src1/2, alu_aluc  operands and op code sent to the external ALU
//   alu_out, alu_*      result and flags returned by the ALU
//   out_*               registered result entry and downstream handshake
// REG_INPUTS=0: ALU fed straight from in_* (latency 1).
// REG_INPUTS=1: a skid register sits in front of the ALU (latency 2).
module exec_stage #(
   parameter bit REG_INPUTS = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7b5,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_rd,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   output logic [3:0]  alu_aluc,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   input  logic        alu_cout,
   input  logic        alu_overflow,
   input  logic        alu_sign,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [31:0] out_store_data,
   output logic [4:0]  out_rd,
   output logic        out_we,
   output logic        out_mem_rd,
   output logic        out_mem_wr,
   output logic [2:0]  out_funct3,
   output logic        out_redirect,
   output logic [31:0] out_target,
   output logic        out_illegal
);
   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // Entry currently presented to the ALU (input bus or skid register)
   logic            e_valid;
   logic [6:0]      e_opcode;
   logic [2:0]      e_funct3;
   logic            e_funct7b5;
   logic [XLEN-1:0] e_pc, e_rs1, e_rs2, e_imm;
   logic [4:0]      e_rd;

   logic out_valid_q;
   logic out_can_load;
   logic out_load;

   assign out_can_load = !out_valid_q || out_ready;
   assign out_load     = e_valid && out_can_load && !flush;

   if (REG_INPUTS) begin : g_skid
      logic            sk_valid_q;
      logic [6:0]      sk_opcode_q;
      logic [2:0]      sk_funct3_q;
      logic            sk_funct7b5_q;
      logic [XLEN-1:0] sk_pc_q, sk_rs1_q, sk_rs2_q, sk_imm_q;
      logic [4:0]      sk_rd_q;

      assign in_ready = !sk_valid_q || out_can_load;

      // Skid register: loads on accept, empties when the output takes it
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sk_valid_q    <= 1'b0;
            sk_opcode_q   <= '0;
            sk_funct3_q   <= '0;
            sk_funct7b5_q <= 1'b0;
            sk_pc_q       <= '0;
            sk_rs1_q      <= '0;
            sk_rs2_q      <= '0;
            sk_imm_q      <= '0;
            sk_rd_q       <= '0;
         end else if (flush) begin
            sk_valid_q <= 1'b0;
         end else if (in_valid && in_ready) begin
            sk_valid_q    <= 1'b1;
            sk_opcode_q   <= in_opcode;
            sk_funct3_q   <= in_funct3;
            sk_funct7b5_q <= in_funct7b5;
            sk_pc_q       <= in_pc;
            sk_rs1_q      <= in_rs1;
            sk_rs2_q      <= in_rs2;
            sk_imm_q      <= in_imm;
            sk_rd_q       <= in_rd;
         end else if (out_can_load) begin
            sk_valid_q <= 1'b0;
         end
      end

      assign e_valid    = sk_valid_q;
      assign e_opcode   = sk_opcode_q;
      assign e_funct3   = sk_funct3_q;
      assign e_funct7b5 = sk_funct7b5_q;
      assign e_pc       = sk_pc_q;
      assign e_rs1      = sk_rs1_q;
      assign e_rs2      = sk_rs2_q;
      assign e_imm      = sk_imm_q;
      assign e_rd       = sk_rd_q;
   end else begin : g_direct
      assign in_ready   = out_can_load;
      assign e_valid    = in_valid;
      assign e_opcode   = in_opcode;
      assign e_funct3   = in_funct3;
      assign e_funct7b5 = in_funct7b5;
      assign e_pc       = in_pc;
      assign e_rs1      = in_rs1;
      assign e_rs2      = in_rs2;
      assign e_imm      = in_imm;
      assign e_rd       = in_rd;
   end

   function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [XLEN-1:0] pc_plus4, pc_plus_imm;
   logic [XLEN-1:0] src1_c, src2_c, result_d, target_d;
   logic [3:0]      aluc_c;
   logic            we_d, mem_rd_d, mem_wr_d, redirect_d, illegal_d, taken;

   assign pc_plus4    = e_pc + XLEN'(4);
   assign pc_plus_imm = e_pc + e_imm;

   // Decode, operand select and branch resolution
   always_comb begin
      aluc_c     = ALU_ADD;
      src1_c     = e_rs1;
      src2_c     = e_rs2;
      result_d   = alu_out;
      target_d   = '0;
      we_d       = 1'b0;
      mem_rd_d   = 1'b0;
      mem_wr_d   = 1'b0;
      redirect_d = 1'b0;
      illegal_d  = 1'b0;
      taken      = 1'b0;
      case (e_opcode)
         OPC_OP: begin
            aluc_c = arith_op(e_funct3, e_funct7b5);
            we_d   = 1'b1;
         end
         OPC_OP_IMM: begin
            // funct7b5 only selects SRA; ADDI never becomes SUB
            aluc_c = arith_op(e_funct3, (e_funct3 == 3'd5) && e_funct7b5);
            src2_c = e_imm;
            we_d   = 1'b1;
         end
         OPC_LUI: begin
            src1_c = '0;
            src2_c = e_imm;
            we_d   = 1'b1;
         end
         OPC_AUIPC: begin
            src1_c = e_pc;
            src2_c = e_imm;
            we_d   = 1'b1;
         end
         OPC_LOAD: begin
            src2_c   = e_imm;
            mem_rd_d = 1'b1;
            we_d     = 1'b1;
         end
         OPC_STORE: begin
            src2_c   = e_imm;
            mem_wr_d = 1'b1;
         end
         OPC_BRANCH: begin
            aluc_c = ALU_SUB;
            // cout is the borrow of rs1 - rs2
            case (e_funct3)
               3'd0:    taken = alu_zero;
               3'd1:    taken = !alu_zero;
               3'd4:    taken = alu_sign ^ alu_overflow;
               3'd5:    taken = !(alu_sign ^ alu_overflow);
               3'd6:    taken = alu_cout;
               3'd7:    taken = !alu_cout;
               default: illegal_d = 1'b1;
            endcase
            redirect_d = taken;
            target_d   = pc_plus_imm;
         end
         OPC_JAL: begin
            src2_c     = e_imm;
            result_d   = pc_plus4;
            we_d       = 1'b1;
            redirect_d = 1'b1;
            target_d   = pc_plus_imm;
         end
         OPC_JALR: begin
            src2_c     = e_imm;
            result_d   = pc_plus4;
            we_d       = 1'b1;
            redirect_d = 1'b1;
            target_d   = alu_out & ~XLEN'(1);
         end
         default: illegal_d = 1'b1;
      endcase
      if (illegal_d) begin
         result_d   = '0;
         target_d   = '0;
         we_d       = 1'b0;
         mem_rd_d   = 1'b0;
         mem_wr_d   = 1'b0;
         redirect_d = 1'b0;
      end
      if (e_rd == 5'd0) we_d = 1'b0;
   end

   assign alu_src1 = src1_c;
   assign alu_src2 = src2_c;
   assign alu_aluc = aluc_c;

   // Output register: payload changes only on load, so it holds while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q    <= 1'b0;
         out_result     <= '0;
         out_store_data <= '0;
         out_rd         <= '0;
         out_we         <= 1'b0;
         out_mem_rd     <= 1'b0;
         out_mem_wr     <= 1'b0;
         out_funct3     <= '0;
         out_redirect   <= 1'b0;
         out_target     <= '0;
         out_illegal    <= 1'b0;
      end else begin
         if (flush)         out_valid_q <= 1'b0;
         else if (out_load) out_valid_q <= 1'b1;
         else if (out_ready) out_valid_q <= 1'b0;
         if (out_load) begin
            out_result     <= result_d;
            out_store_data <= e_rs2;
            out_rd         <= e_rd;
            out_we         <= we_d;
            out_mem_rd     <= mem_rd_d;
            out_mem_wr     <= mem_wr_d;
            out_funct3     <= e_funct3;
            out_redirect   <= redirect_d;
            out_target     <= target_d;
            out_illegal    <= illegal_d;
         end
      end
   end

   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: instance 0 uses REG_INPUTS=0, instance 1
// uses REG_INPUTS=1; each has its own behavioural ALU. Shared data buses,
// per-instance handshake and flush.
module tb_exec_stage;
   localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LUI = 7'h37, LOAD = 7'h03;
   localparam logic [6:0] STORE = 7'h23, BR = 7'h63, JALR = 7'h67, BAD = 7'h7F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush [2];
   logic        in_valid [2];
   logic        in_ready [2];
   logic        out_ready [2];
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic        in_funct7b5;
   logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
   logic [4:0]  in_rd;
   logic [31:0] alu_src1 [2];
   logic [31:0] alu_src2 [2];
   logic [3:0]  alu_aluc [2];
   logic [31:0] alu_out [2];
   logic        alu_zero [2];
   logic        alu_cout [2];
   logic        alu_overflow [2];
   logic        alu_sign [2];
   logic        out_valid [2];
   logic [31:0] out_result [2];
   logic [31:0] out_store_data [2];
   logic [4:0]  out_rd [2];
   logic        out_we [2];
   logic        out_mem_rd [2];
   logic        out_mem_wr [2];
   logic [2:0]  out_funct3 [2];
   logic        out_redirect [2];
   logic [31:0] out_target [2];
   logic        out_illegal [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Reference ALU: {result, zero, cout(borrow on SUB), overflow, sign}
   function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [32:0] w;
      logic [31:0] r;
      logic        c, v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0];
            c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'd1: begin
            r = a - b;
            c = a < b;
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = {31'd0, $signed(a) < $signed(b)};
         4'd6: r = {31'd0, a < b};
         4'd7: r = a << b[4:0];
         4'd8: r = a >> b[4:0];
         4'd9: r = 32'($signed(a) >>> b[4:0]);
         default: r = 32'd0;
      endcase
      return {r, r == 32'd0, c, v, r[31]};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      exec_stage #(.REG_INPUTS(g == 1)) u_dut (
         .clk(clk), .rst_n(rst_n), .flush(flush[g]),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]),
         .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
         .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
         .alu_src1(alu_src1[g]), .alu_src2(alu_src2[g]), .alu_aluc(alu_aluc[g]),
         .alu_out(alu_out[g]), .alu_zero(alu_zero[g]), .alu_cout(alu_cout[g]),
         .alu_overflow(alu_overflow[g]), .alu_sign(alu_sign[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]),
         .out_result(out_result[g]), .out_store_data(out_store_data[g]),
         .out_rd(out_rd[g]), .out_we(out_we[g]),
         .out_mem_rd(out_mem_rd[g]), .out_mem_wr(out_mem_wr[g]),
         .out_funct3(out_funct3[g]), .out_redirect(out_redirect[g]),
         .out_target(out_target[g]), .out_illegal(out_illegal[g])
      );
      assign {alu_out[g], alu_zero[g], alu_cout[g], alu_overflow[g], alu_sign[g]} =
         alu_model(alu_src1[g], alu_src2[g], alu_aluc[g]);
   end

   task automatic set_entry(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic [31:0] pc, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [31:0] imm,
                            input logic [4:0] rd);
      in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
      in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
   endtask

   // Present one entry for one cycle, then wait until it reaches the output
   task automatic issue(input int d);
      in_valid[d] = 1'b1;
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      if (d == 1) begin @(posedge clk); #1; end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset;
      for (int d = 0; d < 2; d++) begin
         n_vec++; if (out_valid[d] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", d, out_valid[d]); end
         n_vec++; if (out_result[d] !== 32'd0) begin n_err++; $display("FAIL reset_result[%0d]: got %h want 0", d, out_result[d]); end
         n_vec++; if (in_ready[d] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d]: got %b want 1", d, in_ready[d]); end
      end
   endtask

   task automatic test_alu_ops;
      set_entry(OP, 3'd0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3);
      in_valid[0] = 1'b1;
      #1;
      n_vec++; if (alu_aluc[0] !== 4'd0) begin n_err++; $display("FAIL add_aluc: got %0d want 0", alu_aluc[0]); end
      n_vec++; if (alu_src2[0] !== 32'd7) begin n_err++; $display("FAIL add_src2: got %h want 7", alu_src2[0]); end
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      n_vec++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid[0]); end
      n_vec++; if (out_result[0] !== 32'd12) begin n_err++; $display("FAIL add_result: got %h want c", out_result[0]); end
      n_vec++; if (out_we[0] !== 1'b1 || out_rd[0] !== 5'd3) begin n_err++; $display("FAIL add_we_rd: got %b/%0d want 1/3", out_we[0], out_rd[0]); end

      set_entry(OP, 3'd0, 1'b1, 32'h0, 32'd0, 32'd1, 32'h0, 5'd4);
      issue(0);
      n_vec++; if (out_result[0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sub_result: got %h want ffffffff", out_result[0]); end

      set_entry(OPI, 3'd5, 1'b1, 32'h0, 32'h8000_0000, 32'h0, 32'd4, 5'd4);
      issue(0);
      n_vec++; if (out_result[0] !== 32'hF800_0000) begin n_err++; $display("FAIL srai_result: got %h want f8000000", out_result[0]); end

      set_entry(OPI, 3'd0, 1'b1, 32'h0, 32'd10, 32'h0, 32'd3, 5'd4);
      issue(0);
      n_vec++; if (out_result[0] !== 32'd13) begin n_err++; $display("FAIL addi_f7_result: got %h want d", out_result[0]); end

      set_entry(LUI, 3'd0, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h1234_5000, 5'd6);
      issue(0);
      n_vec++; if (out_result[0] !== 32'h1234_5000) begin n_err++; $display("FAIL lui_result: got %h want 12345000", out_result[0]); end
   endtask

   task automatic test_branch;
      set_entry(BR, 3'd4, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0);
      issue(0);
      n_vec++; if (out_redirect[0] !== 1'b1) begin n_err++; $display("FAIL blt_redirect: got %b want 1", out_redirect[0]); end
      n_vec++; if (out_target[0] !== 32'h120) begin n_err++; $display("FAIL blt_target: got %h want 120", out_target[0]); end
      n_vec++; if (out_we[0] !== 1'b0) begin n_err++; $display("FAIL blt_we: got %b want 0", out_we[0]); end
      set_entry(BR, 3'd6, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0);
      issue(0);
      n_vec++; if (out_redirect[0] !== 1'b0) begin n_err++; $display("FAIL bltu_redirect: got %b want 0", out_redirect[0]); end
      set_entry(BR, 3'd0, 1'b0, 32'h200, 32'd9, 32'd9, 32'hFFFF_FFF0, 5'd0);
      issue(0);
      n_vec++; if (out_redirect[0] !== 1'b1 || out_target[0] !== 32'h1F0) begin n_err++; $display("FAIL beq_taken: got %b/%h want 1/1f0", out_redirect[0], out_target[0]); end
      set_entry(BR, 3'd2, 1'b0, 32'h200, 32'd9, 32'd9, 32'h8, 5'd0);
      issue(0);
      n_vec++; if (out_illegal[0] !== 1'b1 || out_redirect[0] !== 1'b0) begin n_err++; $display("FAIL br_f3_2_illegal: got %b/%b want 1/0", out_illegal[0], out_redirect[0]); end
   endtask

   task automatic test_jalr;
      set_entry(JALR, 3'd0, 1'b0, 32'h40, 32'h1001, 32'h0, 32'd2, 5'd1);
      issue(0);
      n_vec++; if (out_result[0] !== 32'h44) begin n_err++; $display("FAIL jalr_result: got %h want 44", out_result[0]); end
      n_vec++; if (out_target[0] !== 32'h1002) begin n_err++; $display("FAIL jalr_target: got %h want 1002", out_target[0]); end
      n_vec++; if (out_redirect[0] !== 1'b1 || out_we[0] !== 1'b1) begin n_err++; $display("FAIL jalr_redir_we: got %b/%b want 1/1", out_redirect[0], out_we[0]); end
      set_entry(JALR, 3'd0, 1'b0, 32'h40, 32'h1001, 32'h0, 32'd2, 5'd0);
      issue(0);
      n_vec++; if (out_we[0] !== 1'b0) begin n_err++; $display("FAIL jalr_rd0_we: got %b want 0", out_we[0]); end
   endtask

   task automatic test_mem;
      set_entry(LOAD, 3'd2, 1'b0, 32'h0, 32'h100, 32'h0, 32'hFFFF_FFFC, 5'd7);
      issue(0);
      n_vec++; if (out_result[0] !== 32'hFC || out_mem_rd[0] !== 1'b1 || out_we[0] !== 1'b1) begin n_err++; $display("FAIL load: got %h/%b/%b want fc/1/1", out_result[0], out_mem_rd[0], out_we[0]); end
      set_entry(STORE, 3'd1, 1'b0, 32'h0, 32'h300, 32'hCAFE_F00D, 32'h8, 5'd9);
      issue(0);
      n_vec++; if (out_result[0] !== 32'h308 || out_mem_wr[0] !== 1'b1 || out_we[0] !== 1'b0) begin n_err++; $display("FAIL store: got %h/%b/%b want 308/1/0", out_result[0], out_mem_wr[0], out_we[0]); end
      n_vec++; if (out_store_data[0] !== 32'hCAFE_F00D || out_funct3[0] !== 3'd1) begin n_err++; $display("FAIL store_data: got %h/%0d want cafef00d/1", out_store_data[0], out_funct3[0]); end
   endtask

   task automatic test_illegal;
      set_entry(BAD, 3'd0, 1'b0, 32'h0, 32'd5, 32'd7, 32'd1, 5'd5);
      issue(0);
      n_vec++; if (out_illegal[0] !== 1'b1 || out_we[0] !== 1'b0) begin n_err++; $display("FAIL illegal: got %b/%b want 1/0", out_illegal[0], out_we[0]); end
      n_vec++; if (out_result[0] !== 32'd0 || out_mem_rd[0] !== 1'b0 || out_redirect[0] !== 1'b0) begin n_err++; $display("FAIL illegal_clear: got %h/%b/%b want 0/0/0", out_result[0], out_mem_rd[0], out_redirect[0]); end
   endtask

   task automatic test_latency2;
      set_entry(OP, 3'd0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3);
      in_valid[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      n_vec++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL lat2_early: got %b want 0", out_valid[1]); end
      @(posedge clk); #1;
      n_vec++; if (out_valid[1] !== 1'b1 || out_result[1] !== 32'd12) begin n_err++; $display("FAIL lat2_result: got %b/%h want 1/c", out_valid[1], out_result[1]); end
      idle(1);
   endtask

   task automatic test_flush;
      idle(1);
      set_entry(OP, 3'd0, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd2);
      in_valid[0] = 1'b1; flush[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0; flush[0] = 1'b0;
      n_vec++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL flush_accept: got %b want 0", out_valid[0]); end
      in_valid[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0; flush[1] = 1'b1;
      @(posedge clk); #1;
      flush[1] = 1'b0;
      n_vec++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL flush_skid_a: got %b want 0", out_valid[1]); end
      @(posedge clk); #1;
      n_vec++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL flush_skid_b: got %b want 0", out_valid[1]); end
   endtask

   // Stream 8 ADDIs (result = index) with a 3-cycle downstream stall
   task automatic test_stall(input int d);
      int sent, rcv;
      logic acc, take;
      logic [31:0] held;
      sent = 0; rcv = 0; held = '0;
      out_ready[d] = 1'b1;
      idle(2);
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready[d] = !(cyc >= 4 && cyc < 7);
         in_valid[d] = (sent < 8);
         set_entry(OPI, 3'd0, 1'b0, 32'h0, 32'(sent), 32'h0, 32'h0, 5'd1);
         #1;
         acc = in_valid[d] && in_ready[d];
         take = out_valid[d] && out_ready[d];
         if (cyc == 4) held = out_result[d];
         if (cyc >= 4 && cyc < 7) begin
            n_vec++; if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b1) begin n_err++; $display("FAIL stall%0d_ready cyc %0d: got %b/%b want 0/1", d, cyc, in_ready[d], out_valid[d]); end
            n_vec++; if (out_result[d] !== held) begin n_err++; $display("FAIL stall%0d_hold cyc %0d: got %h want %h", d, cyc, out_result[d], held); end
         end
         if (take) begin
            n_vec++; if (out_result[d] !== 32'(rcv)) begin n_err++; $display("FAIL stall%0d_order: got %h want %h", d, out_result[d], rcv); end
            rcv++;
         end
         @(posedge clk);
         if (acc) sent++;
         #1;
      end
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      n_vec++; if (rcv != 8 || sent != 8) begin n_err++; $display("FAIL stall%0d_count: got %0d/%0d want 8/8", d, sent, rcv); end
   endtask

   task automatic test_async_reset;
      set_entry(OP, 3'd0, 1'b0, 32'h0, 32'd2, 32'd3, 32'h0, 5'd8);
      in_valid[0] = 1'b1; out_ready[0] = 1'b0;
      in_valid[1] = 1'b1; out_ready[1] = 1'b0;
      idle(3);
      n_vec++; if (out_valid[0] !== 1'b1 || out_valid[1] !== 1'b1) begin n_err++; $display("FAIL arst_pre: got %b/%b want 1/1", out_valid[0], out_valid[1]); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid[0] !== 1'b0 || out_result[0] !== 32'd0 || out_we[0] !== 1'b0) begin n_err++; $display("FAIL arst_clear0: got %b/%h/%b want 0/0/0", out_valid[0], out_result[0], out_we[0]); end
      n_vec++; if (out_valid[1] !== 1'b0 || out_result[1] !== 32'd0) begin n_err++; $display("FAIL arst_clear1: got %b/%h want 0/0", out_valid[1], out_result[1]); end
      in_valid[0] = 1'b0; in_valid[1] = 1'b0;
      out_ready[0] = 1'b1; out_ready[1] = 1'b1;
      #1 rst_n = 1'b1;
      idle(2);
      n_vec++; if (out_valid[0] !== 1'b0 || out_valid[1] !== 1'b0) begin n_err++; $display("FAIL arst_survivor: got %b/%b want 0/0", out_valid[0], out_valid[1]); end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         flush[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      end
      set_entry(7'h0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_alu_ops();
      test_branch();
      test_jalr();
      test_mem();
      test_illegal();
      test_latency2();
      test_flush();
      test_stall(0);
      test_stall(1);
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the RV32I mini-project core; sits between the decode/register-read stage and the memory/writeback stage.
- Decodes opcode/funct fields into the 4-bit ALU operation code and selects operands.
- Drives the external combinational ALU and reads back its result and flags.
- Resolves branches/jumps and registers the result behind a valid/ready handshake with stall and flush support.

Parameters:
- REG_INPUTS, 0, 0: ALU driven directly from the input bus, latency 1; 1: input skid register inserted before the ALU, latency 2.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all in-flight entries (synchronous)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_opcode  in  7  instr[6:0]
- in_funct3  in  3  instr[14:12]
- in_funct7b5  in  1  instr[30]
- in_pc  in  32  instruction address
- in_rs1  in  32  rs1 value
- in_rs2  in  32  rs2 value
- in_imm  in  32  sign-extended immediate
- in_rd  in  5  destination register
- alu_src1  out  32  ALU operand 1
- alu_src2  out  32  ALU operand 2
- alu_aluc  out  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
- alu_out  in  32  ALU result
- alu_zero, alu_cout, alu_overflow, alu_sign  in  1 each  ALU flags
- out_valid  out  1  result register valid
- out_ready  in  1  downstream accepts
- out_result  out  32  writeback value or memory address
- out_store_data  out  32  rs2 passthrough
- out_rd  out  5  destination
- out_we  out  1  register write enable
- out_mem_rd, out_mem_wr  out  1 each  load/store
- out_funct3  out  3  passthrough for load/store width
- out_redirect  out  1  taken branch or jump
- out_target  out  32  redirect address
- out_illegal  out  1  unsupported opcode

Behaviour:
- Reset: every output register 0; in_ready follows its equation.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output stage: in_ready = !out_valid || out_ready.
  - Holds all out_* stable while out_valid && !out_ready.
  - With REG_INPUTS=1, one input register (skid) feeds the ALU and in_ready = !skid_valid || (output can load).
  - Full throughput, one entry per cycle, when never stalled.
- Decode (combinational from the entry presented to the ALU):
  - OP: funct3 0 → ADD/SUB (funct7b5), 1 → SLL, 2 → SLT, 3 → SLTU, 4 → XOR, 5 → SRL/SRA (funct7b5), 6 → OR, 7 → AND; src = rs1, rs2.
  - OP-IMM: same mapping with src2 = imm; funct7b5 used only when funct3 = 5; ADDI never SUB.
  - LUI: ADD 0 + imm. AUIPC: ADD pc + imm.
  - LOAD/STORE: ADD rs1 + imm; result = address.
  - BRANCH: SUB rs1 - rs2.
  - JAL/JALR: ADD rs1 + imm; result = pc+4 from the local adder.
- Branch condition from SUB flags:
  - BEQ zero; BNE !zero.
  - BLT sign^overflow; BGE !(sign^overflow).
  - BLTU cout; BGEU !cout (cout = borrow).
  - funct3 2/3 is illegal.
- Targets:
  - Branch/JAL: pc+imm (local adder, wraps modulo 2^32).
  - JALR: alu_out & ~1.
- out_we: 1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR; forced 0 if rd = 0 or illegal.
- Illegal opcode: out_illegal = 1, out_we = out_mem_rd = out_mem_wr = out_redirect = 0, out_result = 0.
- Flush:
  - Next edge clears out_valid and skid_valid.
  - An accept in the same cycle is dropped (flush wins).
  - out_ready is ignored that cycle.
- Asynchronous reset mid-stall: outputs clear immediately and no entry survives.

Test Plan:
- ADD: rs1=5, rs2=7, rd=3 → alu_aluc=0, one cycle later out_valid=1, out_result=12, out_we=1.
- SUB with rs1=0, rs2=1 → out_result=0xFFFFFFFF. SRAI of 0x80000000 by 4 → 0xF8000000.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 → out_redirect=1, target 0x120. BLTU same operands → out_redirect=0.
- JALR rs1=0x1001, imm=2, pc=0x40, rd=1 → out_result=0x44, out_target=0x1002. Same with rd=0 → out_we=0.
- Stall: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* unchanged. Release → entries drain in order, none lost or duplicated. Repeat with REG_INPUTS=1.
- Flush coincident with accept → out_valid=0 next cycle. Opcode 0x7F → out_illegal=1, out_we=0.
